// File: rtl/sd_crc_lanes_if.sv
// Bus bundle for sd_crc_lanes: frame control, input beat stream, CRC output
// stream and frame status. The master side drives frames; the slave side is
// the CRC engine.
interface sd_crc_lanes_if #(
    parameter int unsigned CRC_W = 7,
    parameter int unsigned LANES = 1,
    parameter int unsigned LEN_W = 12
);
    logic                     start;
    logic                     mode;
    logic [LEN_W-1:0]         len;
    logic                     in_valid;
    logic [LANES-1:0]         in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [LANES-1:0]         out_data;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;
    logic                     done;
    logic [LANES-1:0]         crc_ok;
    logic [LANES*CRC_W-1:0]   crc;

    modport master (
        output start, mode, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done, crc_ok, crc
    );

    modport slave (
        input  start, mode, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done, crc_ok, crc
    );
endinterface

// File: rtl/sd_crc_lanes.sv
// Multi-lane serial SD CRC engine (CRC7 for CMD, CRC16 for DAT).
// Generate mode appends the CRC bits on the output stream; check mode
// consumes the received CRC bits and reports a per-lane pass/fail.
module sd_crc_lanes #(
    parameter int unsigned      CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY  = 'h09,
    parameter int unsigned      LANES = 1,
    parameter int unsigned      LEN_W = 12
) (
    input logic           clock,
    input logic           reset_n,
    sd_crc_lanes_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] CRC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [LEN_W-1:0] CRC_LAST = LEN_W'(CRC_W - 1);

    logic [1:0]       state;
    logic             mode_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt;
    logic [CRC_W-1:0] crc_q [LANES];
    logic [CRC_W-1:0] crc_d [LANES];
    logic [LANES-1:0] err_q;
    logic [LANES-1:0] err_d;
    logic [LANES-1:0] ok_q;

    logic data_beat;
    logic crc_beat;
    logic data_last;
    logic crc_last;

    assign data_beat = (state == DATA) && bus.in_valid;
    assign crc_beat  = (state == CRC) && (mode_r ? bus.in_valid : bus.out_ready);
    assign data_last = (cnt == len_r - LEN_W'(1));
    assign crc_last  = (cnt == CRC_LAST);

    assign bus.in_ready  = (state == DATA) || ((state == CRC) && mode_r);
    assign bus.out_valid = (state == CRC) && !mode_r;
    assign bus.out_last  = (state == CRC) && !mode_r && crc_last;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.crc_ok    = ok_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign bus.crc[g*CRC_W +: CRC_W] = crc_q[g];
        assign bus.out_data[g]           = crc_q[g][CRC_W-1];
    end

    // Per-lane next CRC and sticky error: LFSR step on data beats, plain shift on CRC beats
    always_comb begin
        crc_d = crc_q;
        err_d = err_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (data_beat) begin
                crc_d[i] = {crc_q[i][CRC_W-2:0], 1'b0}
                         ^ ((bus.in_data[i] ^ crc_q[i][CRC_W-1]) ? POLY : '0);
            end else if (crc_beat) begin
                crc_d[i] = {crc_q[i][CRC_W-2:0], 1'b0};
                if (mode_r && (bus.in_data[i] != crc_q[i][CRC_W-1])) begin
                    err_d[i] = 1'b1;
                end
            end
        end
    end

    // Frame FSM, bit counter and CRC/error/result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mode_r <= 1'b0;
            len_r  <= '0;
            cnt    <= '0;
            crc_q  <= '{default: '0};
            err_q  <= '0;
            ok_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        crc_q  <= '{default: '0};
                        err_q  <= '0;
                        ok_q   <= '0;
                        mode_r <= bus.mode;
                        len_r  <= bus.len;
                        cnt    <= '0;
                        state  <= (bus.len != '0) ? DATA : CRC;
                    end
                end
                DATA: begin
                    if (bus.in_valid) begin
                        crc_q <= crc_d;
                        if (data_last) begin
                            cnt   <= '0;
                            state <= CRC;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (crc_beat) begin
                        crc_q <= crc_d;
                        err_q <= err_d;
                        if (crc_last) begin
                            // result is registered on entry so it is already valid while done is high
                            cnt   <= '0;
                            ok_q  <= mode_r ? ~err_d : '1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_crc_lanes.sv
// Directed self-checking bench for sd_crc_lanes: SD CMD0/CMD17 CRC7 vectors,
// 512-byte all-ones CRC16 block, 4-lane check mode, len=0, reset mid-frame.
module tb_sd_crc_lanes;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    sd_crc_lanes_if #(.CRC_W(7),  .LANES(1), .LEN_W(12)) b7  ();
    sd_crc_lanes_if #(.CRC_W(16), .LANES(1), .LEN_W(13)) b16 ();
    sd_crc_lanes_if #(.CRC_W(16), .LANES(4), .LEN_W(13)) b4  ();

    sd_crc_lanes #(.CRC_W(7), .POLY(7'h09), .LANES(1), .LEN_W(12)) u7 (
        .clock(clock), .reset_n(reset_n), .bus(b7));
    sd_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(1), .LEN_W(13)) u16 (
        .clock(clock), .reset_n(reset_n), .bus(b16));
    sd_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(4), .LEN_W(13)) u4 (
        .clock(clock), .reset_n(reset_n), .bus(b4));

    always #5 clock = ~clock;

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (b7.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", b7.busy); end
        checks++; if (b7.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", b7.done); end
        checks++; if (b7.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", b7.in_ready); end
        checks++; if (b7.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", b7.out_valid); end
        checks++; if (b7.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b want 0", b7.out_last); end
        checks++; if (b7.out_data !== 1'b0) begin errors++; $display("FAIL reset_out_data got %0b want 0", b7.out_data); end
        checks++; if (b7.crc !== 7'h00) begin errors++; $display("FAIL reset_crc got %h want 00", b7.crc); end
        checks++; if (b4.crc_ok !== 4'b0000) begin errors++; $display("FAIL reset_crc_ok got %b want 0000", b4.crc_ok); end
        checks++; if (b4.crc !== 64'h0) begin errors++; $display("FAIL reset_crc4 got %h want 0", b4.crc); end
        reset_n = 1'b1;
    endtask

    task automatic test_gen7(input logic [39:0] d, input logic [6:0] exp_crc, input string nm);
        logic [6:0] got;
        logic       exp_last;
        got = '0;
        b7.start = 1'b1; b7.mode = 1'b0; b7.len = 12'd40;
        @(negedge clock);
        b7.start = 1'b0;
        checks++; if (b7.busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %0b want 1", nm, b7.busy); end
        checks++; if (b7.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %0b want 1", nm, b7.in_ready); end
        checks++; if (b7.crc_ok !== 1'b0) begin errors++; $display("FAIL %s_ok_cleared got %0b want 0", nm, b7.crc_ok); end
        for (int i = 0; i < 40; i++) begin
            b7.in_valid = 1'b1;
            b7.in_data  = d[39-i];
            // a start mid-frame must not restart the frame
            b7.start = (i == 10);
            b7.len   = (i == 10) ? 12'd0 : 12'd40;
            @(negedge clock);
        end
        b7.in_valid = 1'b0; b7.start = 1'b0; b7.len = 12'd40;
        checks++; if (b7.crc !== exp_crc) begin errors++; $display("FAIL %s_crc got %h want %h", nm, b7.crc, exp_crc); end
        checks++; if (b7.out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got %0b want 1", nm, b7.out_valid); end
        checks++; if (b7.in_ready !== 1'b0) begin errors++; $display("FAIL %s_crc_in_ready got %0b want 0", nm, b7.in_ready); end
        for (int b = 0; b < 7; b++) begin
            exp_last = (b == 6);
            checks++; if (b7.out_last !== exp_last) begin errors++; $display("FAIL %s_out_last%0d got %0b want %0b", nm, b, b7.out_last, exp_last); end
            got[6-b] = b7.out_data;
            b7.out_ready = 1'b1;
            @(negedge clock);
        end
        b7.out_ready = 1'b0;
        checks++; if (got !== exp_crc) begin errors++; $display("FAIL %s_serial got %b want %b", nm, got, exp_crc); end
        checks++; if (b7.done !== 1'b1) begin errors++; $display("FAIL %s_done got %0b want 1", nm, b7.done); end
        checks++; if (b7.busy !== 1'b1) begin errors++; $display("FAIL %s_done_busy got %0b want 1", nm, b7.busy); end
        checks++; if (b7.crc_ok !== 1'b1) begin errors++; $display("FAIL %s_crc_ok got %0b want 1", nm, b7.crc_ok); end
        b7.start = 1'b1;  // coincides with done: must be ignored
        @(negedge clock);
        b7.start = 1'b0;
        checks++; if (b7.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %0b want 0", nm, b7.done); end
        checks++; if (b7.busy !== 1'b0) begin errors++; $display("FAIL %s_start_at_done got busy %0b want 0", nm, b7.busy); end
        checks++; if (b7.crc_ok !== 1'b1) begin errors++; $display("FAIL %s_ok_hold got %0b want 1", nm, b7.crc_ok); end
    endtask

    task automatic test_check7(input logic [39:0] d, input logic [6:0] rx_crc, input logic exp_ok, input string nm);
        b7.start = 1'b1; b7.mode = 1'b1; b7.len = 12'd40;
        @(negedge clock);
        b7.start = 1'b0;
        checks++; if (b7.crc_ok !== 1'b0) begin errors++; $display("FAIL %s_ok_cleared got %0b want 0", nm, b7.crc_ok); end
        for (int i = 0; i < 40; i++) begin
            b7.in_valid = 1'b1; b7.in_data = d[39-i];
            @(negedge clock);
        end
        checks++; if (b7.crc !== 7'h4A) begin errors++; $display("FAIL %s_crc got %h want 4a", nm, b7.crc); end
        checks++; if (b7.out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got %0b want 0", nm, b7.out_valid); end
        checks++; if (b7.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %0b want 1", nm, b7.in_ready); end
        for (int b = 0; b < 7; b++) begin
            b7.in_valid = 1'b1; b7.in_data = rx_crc[6-b];
            @(negedge clock);
        end
        b7.in_valid = 1'b0;
        checks++; if (b7.done !== 1'b1) begin errors++; $display("FAIL %s_done got %0b want 1", nm, b7.done); end
        checks++; if (b7.crc_ok !== exp_ok) begin errors++; $display("FAIL %s_crc_ok got %0b want %0b", nm, b7.crc_ok, exp_ok); end
        @(negedge clock);
        checks++; if (b7.busy !== 1'b0) begin errors++; $display("FAIL %s_idle got busy %0b want 0", nm, b7.busy); end
    endtask

    task automatic test_len0;
        logic exp_last;
        b7.start = 1'b1; b7.mode = 1'b0; b7.len = 12'd0;
        @(negedge clock);
        b7.start = 1'b0;
        checks++; if (b7.out_valid !== 1'b1) begin errors++; $display("FAIL len0_out_valid got %0b want 1", b7.out_valid); end
        checks++; if (b7.crc !== 7'h00) begin errors++; $display("FAIL len0_crc got %h want 00", b7.crc); end
        for (int b = 0; b < 7; b++) begin
            exp_last = (b == 6);
            checks++; if (b7.out_data !== 1'b0) begin errors++; $display("FAIL len0_bit%0d got %0b want 0", b, b7.out_data); end
            checks++; if (b7.out_last !== exp_last) begin errors++; $display("FAIL len0_last%0d got %0b want %0b", b, b7.out_last, exp_last); end
            b7.out_ready = 1'b1;
            @(negedge clock);
        end
        b7.out_ready = 1'b0;
        checks++; if (b7.done !== 1'b1) begin errors++; $display("FAIL len0_done got %0b want 1", b7.done); end
        checks++; if (b7.crc_ok !== 1'b1) begin errors++; $display("FAIL len0_crc_ok got %0b want 1", b7.crc_ok); end
        @(negedge clock);
        b7.len = 12'd40;
    endtask

    task automatic test_reset_mid;
        logic [39:0] d;
        d = 40'h4000000000;
        b7.start = 1'b1; b7.mode = 1'b0; b7.len = 12'd40;
        @(negedge clock);
        b7.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b7.in_valid = 1'b1; b7.in_data = d[39-i];
            @(negedge clock);
        end
        b7.in_valid = 1'b0;
        checks++; if (b7.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %0b want 1", b7.busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (b7.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", b7.busy); end
        checks++; if (b7.crc !== 7'h00) begin errors++; $display("FAIL rstmid_crc got %h want 00", b7.crc); end
        checks++; if (b7.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %0b want 0", b7.in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_gen16_stall;
        logic [15:0] got;
        logic        hold;
        logic        exp_last;
        got = '0;
        b16.start = 1'b1; b16.mode = 1'b0; b16.len = 13'd4096;
        @(negedge clock);
        b16.start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            b16.in_valid = 1'b1; b16.in_data = 1'b1;
            @(negedge clock);
        end
        b16.in_valid = 1'b0;
        checks++; if (b16.crc !== 16'h7FA1) begin errors++; $display("FAIL g16_crc got %h want 7fa1", b16.crc); end
        for (int b = 0; b < 16; b++) begin
            if (b == 5) begin
                b16.out_ready = 1'b0;
                hold = b16.out_data;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    checks++; if (b16.out_data !== hold) begin errors++; $display("FAIL g16_stall%0d got %0b want %0b", k, b16.out_data, hold); end
                    checks++; if (b16.out_valid !== 1'b1) begin errors++; $display("FAIL g16_stall_valid%0d got %0b want 1", k, b16.out_valid); end
                end
            end
            exp_last = (b == 15);
            checks++; if (b16.out_last !== exp_last) begin errors++; $display("FAIL g16_last%0d got %0b want %0b", b, b16.out_last, exp_last); end
            got[15-b] = b16.out_data;
            b16.out_ready = 1'b1;
            @(negedge clock);
        end
        b16.out_ready = 1'b0;
        checks++; if (got !== 16'h7FA1) begin errors++; $display("FAIL g16_serial got %h want 7fa1", got); end
        checks++; if (b16.done !== 1'b1) begin errors++; $display("FAIL g16_done got %0b want 1", b16.done); end
        @(negedge clock);
    endtask

    task automatic test_check4;
        logic [15:0] good;
        logic [15:0] bad;
        good = 16'h7FA1;
        bad  = 16'h7FA0;
        b4.start = 1'b1; b4.mode = 1'b1; b4.len = 13'd4096;
        @(negedge clock);
        b4.start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            b4.in_valid = 1'b1; b4.in_data = 4'hF;
            @(negedge clock);
        end
        checks++; if (b4.crc !== {4{16'h7FA1}}) begin errors++; $display("FAIL c4_crc got %h want 7fa1 x4", b4.crc); end
        for (int b = 0; b < 16; b++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = {bad[15-b], good[15-b], good[15-b], good[15-b]};
            @(negedge clock);
        end
        b4.in_valid = 1'b0;
        checks++; if (b4.done !== 1'b1) begin errors++; $display("FAIL c4_done got %0b want 1", b4.done); end
        checks++; if (b4.crc_ok !== 4'b0111) begin errors++; $display("FAIL c4_crc_ok got %b want 0111", b4.crc_ok); end
        @(negedge clock);
        checks++; if (b4.crc_ok !== 4'b0111) begin errors++; $display("FAIL c4_ok_hold got %b want 0111", b4.crc_ok); end
    endtask

    initial begin
        clock = 1'b0;
        reset_n = 1'b0;
        b7.start = 1'b0;  b7.mode = 1'b0;  b7.len = '0;  b7.in_valid = 1'b0;  b7.in_data = '0;  b7.out_ready = 1'b0;
        b16.start = 1'b0; b16.mode = 1'b0; b16.len = '0; b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b0;
        b4.start = 1'b0;  b4.mode = 1'b0;  b4.len = '0;  b4.in_valid = 1'b0;  b4.in_data = '0;  b4.out_ready = 1'b0;
        test_reset;
        test_gen7(40'h4000000000, 7'h4A, "cmd0");
        test_gen7(40'h5100000000, 7'h2A, "cmd17");
        test_len0;
        test_check7(40'h4000000000, 7'h4A, 1'b1, "chk_good");
        test_check7(40'h4000000000, 7'h4B, 1'b0, "chk_bad");
        test_reset_mid;
        test_gen7(40'h4000000000, 7'h4A, "after_rst");
        test_gen16_stall;
        test_check4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_crc_lanes.md
SD_CRC_LANES -- requirements
Module: sd_crc_lanes

Interface
REQ-001 Parameter CRC_W, default 7: CRC width in bits; legal values 7 (CMD line) and 16 (DAT lines).
REQ-002 Parameter POLY, default 7'h09: generator polynomial without the x^CRC_W term; the value for CRC_W=16 is 16'h1021.
REQ-003 Parameter LANES, default 1: number of parallel serial lanes; legal values 1 and 4.
REQ-004 Parameter LEN_W, default 12: width of the length input.
REQ-005 clock  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  begins a frame; sampled only in IDLE.
REQ-008 mode  in  1  sampled with start; 0 = generate (TX), 1 = check (RX).
REQ-009 len  in  LEN_W  data bits per lane for the frame; sampled with start.
REQ-010 in_valid  in  1  input beat valid.
REQ-011 in_data  in  LANES  one bit per lane per beat; lane i is bit i.
REQ-012 in_ready  out  1  module accepts an input beat.
REQ-013 out_valid  out  1  CRC bit available (generate mode).
REQ-014 out_data  out  LANES  current CRC MSB of each lane.
REQ-015 out_ready  in  1  consumer takes the out_data beat.
REQ-016 out_last  out  1  current out beat is the final CRC bit.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse at frame end.
REQ-019 crc_ok  out  LANES  per-lane check result; valid from done until the next start.
REQ-020 crc  out  LANES*CRC_W  CRC registers; lane i occupies bits [i*CRC_W +: CRC_W].

Function
REQ-021 Per-lane update on each accepted beat SHALL be: fb = bit ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-022 The FSM SHALL have the states IDLE, DATA, CRC and DONE.
REQ-023 In IDLE, start SHALL clear all CRC registers and crc_ok to 0, latch mode and len, and clear the bit counter.
REQ-024 On start in IDLE, the next state SHALL be DATA if len != 0, else CRC.
REQ-025 In IDLE, in_ready=0 and out_valid=0.
REQ-026 In DATA: in_ready=1; each cycle with in_valid=1 updates every lane per REQ-021 and increments the counter.
REQ-027 DATA SHALL go to CRC on the beat where counter == len-1, and clear the counter on that transition.
REQ-028 Cycles in DATA with in_valid=0 SHALL change no state.
REQ-029 CRC, generate mode: out_valid=1, in_ready=0, out_data[i]=crc_i[CRC_W-1].
REQ-030 CRC, generate mode: on out_ready=1, every lane shifts left with zero fill and the counter increments.
REQ-031 CRC, generate mode: out_last=1 when counter == CRC_W-1; the beat accepted with out_last=1 goes to DONE.
REQ-032 CRC, check mode: in_ready=1, out_valid=0.
REQ-033 CRC, check mode: each accepted beat compares in_data[i] with crc_i[CRC_W-1]; a mismatch sets a sticky per-lane error; then all lanes shift left as in REQ-030.
REQ-034 CRC, check mode: the CRC_W-th accepted beat goes to DONE.
REQ-035 DONE SHALL last exactly one cycle with done=1, busy=1, then return to IDLE.
REQ-036 In DONE, crc_ok[i] = ~error[i] in check mode, and all ones in generate mode; crc_ok holds until the next start.
REQ-037 The crc output SHALL show the live registers, so it holds the final data-phase CRC on the cycle DATA->CRC.
REQ-038 start outside IDLE SHALL be ignored.
REQ-039 A start asserted together with done SHALL be ignored; a new frame needs start in IDLE.
REQ-040 Counter width SHALL be LEN_W; len = 2^LEN_W-1 is supported without overflow.

Reset
REQ-041 Asserting reset_n=0 at any time, including mid-frame, SHALL immediately force IDLE and zero all CRC registers, counters and error flags.
REQ-042 During reset: crc_ok=0, done=0, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0.
REQ-043 Deassertion of reset_n is assumed synchronous to clock by the system.

Verification
REQ-044 CRC_W=7, POLY=09, LANES=1, generate, len=40, bits of 0x4000000000 MSB first -> crc=7'h4A; out_data serial 1001010; out_last on the 7th beat; done one cycle later.
REQ-045 Same config, bits of 0x5100000000 -> crc=7'h2A.
REQ-046 CRC_W=16, POLY=1021, LANES=1, generate, len=4096, all ones -> crc=16'h7FA1; 16 out beats; stall out_ready for 3 cycles mid-stream -> out_data held, no beat lost.
REQ-047 CRC_W=16, LANES=4, check mode; feed data then the correct CRC on lanes 0-2 and lane 3 CRC with 1 bit flipped -> crc_ok=4'b0111 at done.
REQ-048 Reset mid-DATA at beat 20 of 40 -> busy=0 and crc=0 the same cycle; a fresh frame afterwards gives the REQ-044 result.
REQ-049 len=0 in generate mode -> straight to CRC; 7 out beats all 0; done; crc_ok=1.
